regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 104 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Two-requester round-robin write-back arbiter feeding one register-bank write port.
// Grants are combinational; the granted write is registered and presented one cycle later.
module regfile_wb_arbiter #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              req0_valid,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_data,
  output logic              req1_ready,
  output logic              rb_wen,
  output logic [AWIDTH-1:0] rb_waddr,
  output logic [DWIDTH-1:0] rb_wdata,
  output logic              last_grant,
  output logic [7:0]        wr_count,
  output logic [7:0]        drop_count
);

  // Handshake: a write moves on requester i in any cycle where reqi_valid && reqi_ready.
  // Ready depends only on the valids, stall, rst and last_grant, never on addr/data,
  // and at most one ready is high per cycle.

  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic              addr_zero;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_data;

  logic              last_grant_q, last_grant_d;
  logic              rb_wen_q, rb_wen_d;
  logic [AWIDTH-1:0] rb_waddr_q, rb_waddr_d;
  logic [DWIDTH-1:0] rb_wdata_q, rb_wdata_d;
  logic [7:0]        wr_count_q, wr_count_d;
  logic [7:0]        drop_count_q, drop_count_d;

  // With both valid, the requester that did not win last time wins now.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !stall) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  always_comb begin
    xfer      = grant0 || grant1;
    sel_addr  = grant1 ? req1_addr : req0_addr;
    sel_data  = grant1 ? req1_data : req0_data;
    addr_zero = (sel_addr == '0);

    last_grant_d = xfer ? grant1 : last_grant_q;

    // Writes to register 0 are accepted but never reach the bank.
    rb_wen_d   = xfer && !addr_zero;
    rb_waddr_d = rb_wen_d ? sel_addr : rb_waddr_q;
    rb_wdata_d = rb_wen_d ? sel_data : rb_wdata_q;

    wr_count_d   = (rb_wen_d && (wr_count_q != 8'hFF)) ? wr_count_q + 8'd1 : wr_count_q;
    drop_count_d = (xfer && addr_zero && (drop_count_q != 8'hFF))
                   ? drop_count_q + 8'd1 : drop_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      rb_wen_q     <= 1'b0;
      rb_waddr_q   <= '0;
      rb_wdata_q   <= '0;
      wr_count_q   <= 8'd0;
      drop_count_q <= 8'd0;
    end else begin
      last_grant_q <= last_grant_d;
      rb_wen_q     <= rb_wen_d;
      rb_waddr_q   <= rb_waddr_d;
      rb_wdata_q   <= rb_wdata_d;
      wr_count_q   <= wr_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rb_wen     = rb_wen_q;
  assign rb_waddr   = rb_waddr_q;
  assign rb_wdata   = rb_wdata_q;
  assign last_grant = last_grant_q;
  assign wr_count   = wr_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: grants checked at issue, bank writes
// checked by a monitor against an expected queue of {cycle, addr, data}.
module tb_regfile_wb_arbiter;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int EW = 32 + AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          rb_wen;
  logic [AW-1:0] rb_waddr;
  logic [DW-1:0] rb_wdata;
  logic          last_grant;
  logic [7:0]    wr_count, drop_count;

  regfile_wb_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rb_wen(rb_wen), .rb_waddr(rb_waddr), .rb_wdata(rb_wdata),
    .last_grant(last_grant), .wr_count(wr_count), .drop_count(drop_count)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  int   exp_wr = 0;
  int   exp_drop = 0;
  logic exp_last = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every bank write must match the head of the expected queue in the right cycle
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (exp_q.size() > 0 && int'(exp_q[0][EW-1:AW+DW]) < cyc) begin
        check("wr_missing", 32'd0, 32'd1);
        void'(exp_q.pop_front());
      end
      if (rb_wen !== 1'b0) begin
        if (exp_q.size() == 0) begin
          check("wr_spurious", {31'd0, rb_wen}, 32'd0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("wr_cycle", cyc, e[EW-1:AW+DW]);
          check("wr_addr", {29'd0, rb_waddr}, {29'd0, e[AW+DW-1:DW]});
          check("wr_data", {24'd0, rb_wdata}, {24'd0, e[DW-1:0]});
        end
      end
    end
  end

  // driver: apply one cycle of stimulus; eg = expected {req1_ready, req0_ready}
  task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic st, input logic [1:0] eg, input string tag);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    stall = st;
    @(negedge clk);
    check({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, {30'd0, eg});
    if (eg != 2'b00) begin
      a = eg[1] ? a1 : a0;
      d = eg[1] ? d1 : d0;
      exp_last = eg[1];
      if (a != '0) begin
        exp_q.push_back({32'(cyc + 1), a, d});
        if (exp_wr < 255) exp_wr++;
      end else if (exp_drop < 255) begin
        exp_drop++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 2'b00, "idle");
  endtask

  task automatic check_state(input string tag);
    check({tag, "_wr_count"}, {24'd0, wr_count}, exp_wr);
    check({tag, "_drop_count"}, {24'd0, drop_count}, exp_drop);
    check({tag, "_last_grant"}, {31'd0, last_grant}, {31'd0, exp_last});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready0"}, {31'd0, req0_ready}, 32'd0);
    check({tag, "_ready1"}, {31'd0, req1_ready}, 32'd0);
    check({tag, "_rb_wen"}, {31'd0, rb_wen}, 32'd0);
    check({tag, "_rb_waddr"}, {29'd0, rb_waddr}, 32'd0);
    check({tag, "_rb_wdata"}, {24'd0, rb_wdata}, 32'd0);
    check({tag, "_last_grant"}, {31'd0, last_grant}, 32'd1);
    check({tag, "_wr_count"}, {24'd0, wr_count}, 32'd0);
    check({tag, "_drop_count"}, {24'd0, drop_count}, 32'd0);
  endtask

  // reset with both requesters valid so ready gating by rst is exercised
  task automatic do_reset();
    rst = 1'b1; stall = 1'b0;
    req0_valid = 1'b1; req0_addr = 3'd6; req0_data = 8'h66;
    req1_valid = 1'b1; req1_addr = 3'd7; req1_data = 8'h77;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    exp_wr = 0; exp_drop = 0; exp_last = 1'b1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    do_reset();

    // single write on req0, one-cycle latency
    step(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 1'b0, 2'b01, "single");
    idle(1);
    check_state("single");

    // fresh reset: first contention goes to req0, then strict alternation without bubbles
    do_reset();
    step(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0, 2'b01, "rr0");
    step(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0, 2'b10, "rr1");
    step(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0, 2'b01, "rr2");
    step(1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0, 2'b10, "rr3");
    idle(1);
    check_state("rr");

    // write to register 0 is accepted and dropped
    step(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'hFF, 1'b0, 2'b10, "drop");
    idle(1);
    check_state("drop");

    // stall holds off both; round-robin resumes with req0 (req1 won last)
    step(1'b1, 3'd4, 8'h40, 1'b1, 3'd5, 8'h50, 1'b1, 2'b00, "stall0");
    step(1'b1, 3'd4, 8'h40, 1'b1, 3'd5, 8'h50, 1'b1, 2'b00, "stall1");
    step(1'b1, 3'd4, 8'h40, 1'b1, 3'd5, 8'h50, 1'b1, 2'b00, "stall2");
    step(1'b1, 3'd4, 8'h40, 1'b1, 3'd5, 8'h50, 1'b0, 2'b01, "resume0");
    step(1'b1, 3'd4, 8'h41, 1'b1, 3'd5, 8'h51, 1'b0, 2'b10, "resume1");
    idle(1);
    check_state("stall");

    // same destination from both requesters lands in grant order
    step(1'b1, 3'd6, 8'h10, 1'b1, 3'd6, 8'h20, 1'b0, 2'b01, "same0");
    step(1'b1, 3'd6, 8'h10, 1'b1, 3'd6, 8'h20, 1'b0, 2'b10, "same1");
    idle(2);

    // accepted transfer cancelled by reset before the capturing edge
    req0_valid = 1'b1; req0_addr = 3'd5; req0_data = 8'h5C;
    req1_valid = 1'b0; stall = 1'b0;
    @(negedge clk);
    check("midrst_ready_pre", {31'd0, req0_ready}, 32'd1);
    #2 rst = 1'b1;
    #1 check("midrst_ready_gated", {31'd0, req0_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    req0_valid = 1'b0; rst = 1'b0;
    exp_wr = 0; exp_drop = 0; exp_last = 1'b1;
    idle(2);
    check_state("midrst");

    // wr_count saturation
    for (int i = 0; i < 300; i++)
      step(1'b1, 3'((i % 7) + 1), 8'(i), 1'b0, 3'd0, 8'h00, 1'b0, 2'b01, "sat_wr");
    idle(1);
    check_state("sat_wr");
    step(1'b1, 3'd2, 8'hEE, 1'b0, 3'd0, 8'h00, 1'b0, 2'b01, "sat_wr_more");
    idle(1);
    check_state("sat_wr_hold");

    // drop_count saturation
    for (int i = 0; i < 260; i++)
      step(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'(i), 1'b0, 2'b10, "sat_drop");
    idle(1);
    check_state("sat_drop");

    idle(3);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
